// File: rtl/synth_pkg.sv
// Shared types and constants for the synth control-side blocks.
package synth_pkg;

    localparam int unsigned NOTE_DEPTH_DEF = 7;
    localparam int unsigned AGE_DEPTH_DEF  = 4;

    // Largest value an age counter of the given width can hold before saturating.
    function automatic int unsigned age_max(input int unsigned depth);
        return (32'd1 << depth) - 32'd1;
    endfunction

    localparam int unsigned AGE_SAT_DEF = age_max(AGE_DEPTH_DEF);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RETRIG = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/voice_select.sv
// Combinational note-on voice picker: same-note retrigger, free voice,
// oldest released voice, then oldest gated voice (steal).
module voice_select
    import synth_pkg::*;
#(
    parameter int unsigned VOICES     = 4,
    parameter int unsigned NOTE_DEPTH = NOTE_DEPTH_DEF,
    parameter int unsigned AGE_DEPTH  = AGE_DEPTH_DEF,
    parameter int unsigned IDX_W      = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic [VOICES-1:0]            gate_i,
    input  logic [VOICES-1:0]            running_i,
    input  logic [VOICES*NOTE_DEPTH-1:0] voice_note_i,
    input  logic [VOICES*AGE_DEPTH-1:0]  ages_i,
    input  logic [NOTE_DEPTH-1:0]        note_i,
    output logic [IDX_W-1:0]             sel_c_o,
    output logic                         retrig_c_o,
    output logic                         steal_c_o
);

    logic                 same_found, free_found, rel_found, gated_found;
    logic [IDX_W-1:0]     same_idx, free_idx, rel_idx, old_idx;
    logic [AGE_DEPTH-1:0] rel_age, old_age, age_v;

    // Candidate scan per rule; strict '>' keeps the lowest index on age ties.
    always_comb begin
        same_found  = 1'b0;
        free_found  = 1'b0;
        rel_found   = 1'b0;
        gated_found = 1'b0;
        same_idx    = '0;
        free_idx    = '0;
        rel_idx     = '0;
        old_idx     = '0;
        rel_age     = '0;
        old_age     = '0;
        age_v       = '0;
        for (int i = 0; i < VOICES; i++) begin
            age_v = ages_i[i*AGE_DEPTH +: AGE_DEPTH];
            if (gate_i[i] && (voice_note_i[i*NOTE_DEPTH +: NOTE_DEPTH] == note_i) && !same_found) begin
                same_found = 1'b1;
                same_idx   = IDX_W'(i);
            end
            if (!gate_i[i] && !running_i[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!gate_i[i] && running_i[i] && (!rel_found || (age_v > rel_age))) begin
                rel_found = 1'b1;
                rel_idx   = IDX_W'(i);
                rel_age   = age_v;
            end
            if (gate_i[i] && (!gated_found || (age_v > old_age))) begin
                gated_found = 1'b1;
                old_idx     = IDX_W'(i);
                old_age     = age_v;
            end
        end
    end

    always_comb begin
        sel_c_o    = old_idx;
        retrig_c_o = 1'b0;
        steal_c_o  = 1'b0;
        if (same_found) begin
            sel_c_o    = same_idx;
            retrig_c_o = 1'b1;
        end else if (free_found) begin
            sel_c_o = free_idx;
        end else if (rel_found) begin
            sel_c_o = rel_idx;
        end else begin
            retrig_c_o = gated_found;
            steal_c_o  = gated_found;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice allocator driving per-voice envelope gates, with
// oldest-voice stealing and a one-cycle gate-low gap on retrigger.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned VOICES     = 4,
    parameter int unsigned NOTE_DEPTH = NOTE_DEPTH_DEF,
    parameter int unsigned AGE_DEPTH  = AGE_DEPTH_DEF
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         NoteValid,
    input  logic                         NoteOn,
    input  logic [NOTE_DEPTH-1:0]        Note,
    output logic                         NoteReady,
    input  logic [VOICES-1:0]            Running,
    output logic [VOICES-1:0]            Gate,
    output logic [VOICES*NOTE_DEPTH-1:0] VoiceNote,
    output logic                         Stolen
);

    localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [AGE_DEPTH-1:0] AGE_SAT = AGE_DEPTH'(age_max(AGE_DEPTH));

    alloc_state_e                state_q, state_d;
    logic [VOICES-1:0]            gate_q, gate_d;
    logic [VOICES*NOTE_DEPTH-1:0] vnote_q, vnote_d;
    logic [VOICES*AGE_DEPTH-1:0]  ages_q, ages_d;
    logic [NOTE_DEPTH-1:0]        latch_note_q, latch_note_d;
    logic [IDX_W-1:0]             latch_idx_q, latch_idx_d;
    logic                         stolen_q, stolen_d;
    logic                         ready_q, ready_d;

    logic                         accept;
    logic [IDX_W-1:0]             sel_c;
    logic                         retrig_c, steal_c;
    logic [AGE_DEPTH-1:0]         age_v;

    assign accept = NoteValid & ready_q;

    voice_select #(
        .VOICES     (VOICES),
        .NOTE_DEPTH (NOTE_DEPTH),
        .AGE_DEPTH  (AGE_DEPTH),
        .IDX_W      (IDX_W)
    ) u_select (
        .gate_i       (gate_q),
        .running_i    (Running),
        .voice_note_i (vnote_q),
        .ages_i       (ages_q),
        .note_i       (Note),
        .sel_c_o      (sel_c),
        .retrig_c_o   (retrig_c),
        .steal_c_o    (steal_c)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && NoteOn && retrig_c) state_d = ST_RETRIG;
            ST_RETRIG: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Gate/note/age updates; a retrigger parks the voice low for one cycle.
    always_comb begin
        gate_d       = gate_q;
        vnote_d      = vnote_q;
        ages_d       = ages_q;
        latch_note_d = latch_note_q;
        latch_idx_d  = latch_idx_q;
        stolen_d     = 1'b0;
        ready_d      = (state_d == ST_IDLE);
        age_v        = '0;
        case (state_q)
            ST_RETRIG: begin
                for (int i = 0; i < VOICES; i++) begin
                    if (IDX_W'(i) == latch_idx_q) begin
                        gate_d[i]                            = 1'b1;
                        vnote_d[i*NOTE_DEPTH +: NOTE_DEPTH] = latch_note_q;
                    end
                end
            end
            default: begin
                if (accept && NoteOn) begin
                    stolen_d = steal_c;
                    if (retrig_c) begin
                        latch_note_d = Note;
                        latch_idx_d  = sel_c;
                    end
                    for (int i = 0; i < VOICES; i++) begin
                        age_v = ages_q[i*AGE_DEPTH +: AGE_DEPTH];
                        if (IDX_W'(i) == sel_c) begin
                            ages_d[i*AGE_DEPTH +: AGE_DEPTH] = '0;
                            gate_d[i]                        = !retrig_c;
                            if (!retrig_c) vnote_d[i*NOTE_DEPTH +: NOTE_DEPTH] = Note;
                        end else if (age_v != AGE_SAT) begin
                            ages_d[i*AGE_DEPTH +: AGE_DEPTH] = age_v + AGE_DEPTH'(1);
                        end
                    end
                end else if (accept) begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (gate_q[i] && (vnote_q[i*NOTE_DEPTH +: NOTE_DEPTH] == Note)) gate_d[i] = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            gate_q       <= '0;
            vnote_q      <= '0;
            ages_q       <= '0;
            latch_note_q <= '0;
            latch_idx_q  <= '0;
            stolen_q     <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            gate_q       <= gate_d;
            vnote_q      <= vnote_d;
            ages_q       <= ages_d;
            latch_note_q <= latch_note_d;
            latch_idx_q  <= latch_idx_d;
            stolen_q     <= stolen_d;
            ready_q      <= ready_d;
        end
    end

    assign Gate      = gate_q;
    assign VoiceNote = vnote_q;
    assign Stolen    = stolen_q;
    assign NoteReady = ready_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, reset-in-retrigger
// sequence, and randomized events against an array-based voice model.
module tb_voice_allocator;
    import synth_pkg::*;

    logic        clk, rst_n;
    logic        nv, on;
    logic [6:0]  note;
    logic [3:0]  run;
    logic        ready, stolen;
    logic [3:0]  gate;
    logic [27:0] vn;

    int total = 0;
    int bad   = 0;

    voice_allocator dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .NoteValid (nv),
        .NoteOn    (on),
        .Note      (note),
        .NoteReady (ready),
        .Running   (run),
        .Gate      (gate),
        .VoiceNote (vn),
        .Stolen    (stolen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_gate[4];
    int m_note[4];
    int m_age[4];
    bit m_pend, m_ready, m_stolen;
    int m_pidx, m_pnote;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_age[i] = 0;
        end
        m_pend = 0; m_ready = 1; m_stolen = 0; m_pidx = 0; m_pnote = 0;
    endfunction

    function automatic logic [33:0] model_out();
        logic [3:0]  g;
        logic [27:0] v;
        for (int i = 0; i < 4; i++) begin
            g[i] = m_gate[i];
            v[i*7 +: 7] = 7'(m_note[i]);
        end
        return {g, v, m_ready, m_stolen};
    endfunction

    function automatic void model_step(input bit s_nv, input bit s_on, input int s_note, input logic [3:0] s_run);
        int v;
        bit steal;
        m_stolen = 0;
        if (m_pend) begin
            m_gate[m_pidx] = 1; m_note[m_pidx] = m_pnote; m_pend = 0;
        end else if (s_nv && s_on) begin
            v = -1; steal = 0;
            for (int i = 0; i < 4; i++) if (v < 0 && m_gate[i] && m_note[i] == s_note) v = i;
            for (int i = 0; i < 4; i++) if (v < 0 && !m_gate[i] && !s_run[i]) v = i;
            if (v < 0) begin
                int best = -1;
                for (int i = 0; i < 4; i++)
                    if (!m_gate[i] && s_run[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
                v = best;
            end
            if (v < 0) begin
                int best = -1;
                for (int i = 0; i < 4; i++)
                    if (m_gate[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
                v = best; steal = 1;
            end
            for (int i = 0; i < 4; i++)
                m_age[i] = (i == v) ? 0 : ((m_age[i] < int'(AGE_SAT_DEF)) ? m_age[i] + 1 : m_age[i]);
            if (m_gate[v]) begin
                m_gate[v] = 0; m_pend = 1; m_pidx = v; m_pnote = s_note; m_stolen = steal;
            end else begin
                m_gate[v] = 1; m_note[v] = s_note;
            end
        end else if (s_nv) begin
            for (int i = 0; i < 4; i++) if (m_gate[i] && m_note[i] == s_note) m_gate[i] = 0;
        end
        m_ready = !m_pend;
    endfunction

    // One cycle: drive at negedge, step model at posedge, compare at next negedge.
    task automatic drive_cycle(input string name, input bit d_nv, input bit d_on, input int d_note, input logic [3:0] d_run);
        nv = d_nv; on = d_on; note = 7'(d_note); run = d_run;
        @(posedge clk);
        model_step(d_nv, d_on, d_note, d_run);
        @(negedge clk);
        check(name, 64'({gate, vn, ready, stolen}), 64'(model_out()));
    endtask

    task automatic do_reset();
        nv = 0; on = 0; note = '0; run = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        nv;
        logic        on;
        logic [6:0]  note;
        logic [3:0]  run;
        logic [3:0]  gate;
        logic [27:0] vn;
        logic        ready;
        logic        stolen;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 7'd60, 4'h0, 4'b0001, {7'd0,  7'd0,  7'd0,  7'd60}, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 7'd62, 4'h0, 4'b0011, {7'd0,  7'd0,  7'd62, 7'd60}, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 7'd64, 4'h0, 4'b0111, {7'd0,  7'd64, 7'd62, 7'd60}, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 7'd65, 4'h0, 4'b1111, {7'd65, 7'd64, 7'd62, 7'd60}, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 7'd67, 4'hF, 4'b1110, {7'd65, 7'd64, 7'd62, 7'd60}, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 7'd0,  4'hF, 4'b1111, {7'd65, 7'd64, 7'd62, 7'd67}, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 7'd62, 4'hF, 4'b1101, {7'd65, 7'd64, 7'd62, 7'd67}, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 7'd70, 4'hF, 4'b1111, {7'd65, 7'd64, 7'd70, 7'd67}, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 7'd99, 4'hF, 4'b1111, {7'd65, 7'd64, 7'd70, 7'd67}, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 7'd67, 4'hF, 4'b1110, {7'd65, 7'd64, 7'd70, 7'd67}, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 7'd0,  4'hF, 4'b1111, {7'd65, 7'd64, 7'd70, 7'd67}, 1'b1, 1'b0};

        rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        check("reset_state", 64'({gate, vn, ready, stolen}), 64'({4'b0000, 28'd0, 1'b1, 1'b0}));

        foreach (tbl[i]) begin
            nv = tbl[i].nv; on = tbl[i].on; note = tbl[i].note; run = tbl[i].run;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'({gate, vn, ready, stolen}),
                  64'({tbl[i].gate, tbl[i].vn, tbl[i].ready, tbl[i].stolen}));
        end

        // Reset asserted while a retrigger is pending.
        do_reset();
        drive_cycle("rr_on60", 1, 1, 60, 4'h0);
        drive_cycle("rr_on62", 1, 1, 62, 4'h0);
        drive_cycle("rr_retrig60", 1, 1, 60, 4'h0);
        check("rr_in_retrig", 64'({gate, ready}), 64'({4'b0010, 1'b0}));
        nv = 0;
        #2 rst_n = 1'b0;
        #1 check("rr_async_clear", 64'({gate, vn, ready, stolen}), 64'({4'b0000, 28'd0, 1'b1, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_cycle("rr_no_stale1", 0, 0, 0, 4'h0);
        drive_cycle("rr_no_stale2", 0, 0, 0, 4'h0);
        check("rr_gate_zero", 64'({gate, ready}), 64'({4'b0000, 1'b1}));

        // Age saturation: hammer voice 0, others saturate and tie at the max.
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle("sat_fill", 1, 1, 60 + i, 4'h0);
        for (int i = 0; i < 50; i++) drive_cycle("sat_hammer", 1, 1, 60, 4'hF);
        drive_cycle("sat_settle", 0, 0, 0, 4'hF);
        drive_cycle("sat_steal", 1, 1, 70, 4'hF);
        check("sat_tie_lowest", 64'({gate, stolen}), 64'({4'b1101, 1'b1}));
        drive_cycle("sat_after", 0, 0, 0, 4'hF);

        // Randomized events over a small note range to force matches and steals.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6),
                        int'($urandom_range(60, 67)), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
